// File: rtl/multdiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM states,
// the ALU opcodes that the decoder turns into start pulses, and the default iteration count.
package multdiv_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_t;

  localparam logic [4:0] ALU_OP_MUL = 5'b00110;
  localparam logic [4:0] ALU_OP_DIV = 5'b00111;

  localparam int unsigned ITER_DEFAULT = 32;

  function automatic logic is_muldiv_op(input logic [4:0] op);
    return (op == ALU_OP_MUL) || (op == ALU_OP_DIV);
  endfunction

endpackage

// File: rtl/multdiv_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it is non-negative.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = w_shift - {1'b0, i_dvsr};
    o_qbit  = ~w_diff[WIDTH];
    o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit for the
// execute stage; fixed ITER+1 cycle latency, busy drives the pipeline stall.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = ITER_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CW = $clog2(ITER) + 1;
  localparam logic [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_t          r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH:0]   r_prod;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic               r_neg;
  logic               r_dz;
  logic               r_ovf;
  logic [WIDTH-1:0]   r_result;
  logic               r_exc;
  logic               r_rdy;
  logic               r_busy;

  logic               w_start;
  logic               w_last;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_acc;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH:0]   w_prod_nxt;
  logic [WIDTH-1:0]   w_mul_lo;
  logic [WIDTH-1:0]   w_mul_hi;
  logic               w_mul_exc;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [WIDTH-1:0]   w_div_res;
  logic               w_div_exc;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_last  = (r_cnt == CW'(ITER - 1));
  assign w_a_mag = data_operandA[WIDTH-1] ? ('0 - data_operandA) : data_operandA;
  assign w_b_mag = data_operandB[WIDTH-1] ? ('0 - data_operandB) : data_operandB;

  // Booth add is done one bit wider so a most-negative multiplicand cannot overflow
  // the accumulator before the arithmetic shift.
  always_comb begin
    w_acc = {r_prod[2*WIDTH], r_prod[2*WIDTH:WIDTH+1]};
    case (r_prod[1:0])
      2'b01:   w_sum = w_acc + {r_mcand[WIDTH-1], r_mcand};
      2'b10:   w_sum = w_acc - {r_mcand[WIDTH-1], r_mcand};
      default: w_sum = w_acc;
    endcase
    w_prod_nxt = {w_sum, r_prod[WIDTH:1]};
    w_mul_lo   = w_prod_nxt[WIDTH:1];
    w_mul_hi   = w_prod_nxt[2*WIDTH:WIDTH+1];
    w_mul_exc  = (w_mul_hi != {WIDTH{w_mul_lo[WIDTH-1]}});
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem  (r_rem),
    .i_bit  (r_quo[WIDTH-1]),
    .i_dvsr (r_mcand),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  always_comb begin
    w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};
    w_div_res = r_neg ? ('0 - w_quo_nxt) : w_quo_nxt;
    w_div_exc = 1'b0;
    if (r_dz) begin
      w_div_res = '0;
      w_div_exc = 1'b1;
    end else if (r_ovf) begin
      w_div_res = W_MIN;
      w_div_exc = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else if (w_start) begin
      // A start in any state discards whatever was in flight.
      r_state <= ctrl_MULT ? S_MUL : S_DIV;
      r_cnt   <= '0;
      r_prod  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
      r_mcand <= ctrl_MULT ? data_operandA : w_b_mag;
      r_rem   <= '0;
      r_quo   <= w_a_mag;
      r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_dz    <= (data_operandB == '0);
      r_ovf   <= (data_operandA == W_MIN) && (data_operandB == '1);
      r_rdy   <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_MUL: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_result <= w_mul_lo;
            r_exc    <= w_mul_exc;
            r_rdy    <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_result <= w_div_res;
            r_exc    <= w_div_exc;
            r_rdy    <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_rdy   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_rdy  <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: each start pushes its expected result and
// completion cycle; every RDY pulse pops and compares.
module tb_multdiv_unit;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  multdiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          ncyc;
  int          n_vec;
  int          n_err;
  logic [31:0] last_res;
  logic        last_exc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_rdy", 64'(data_resultRDY), 64'd0);
      end else begin
        e = sb.pop_front();
        check("result", 64'(data_result), 64'(e.res));
        check("exception", 64'(data_exception), 64'(e.exc));
        check("rdy_cycle", 64'(ncyc), 64'(e.cyc));
        last_res = e.res;
        last_exc = e.exc;
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    ncyc++;
    monitor();
  endtask

  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    exp_t             e;
    logic signed [63:0] p;
    logic signed [31:0] q;
    if (sb.size() != 0) void'(sb.pop_back());
    if (m) begin
      p     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      e.res = p[31:0];
      e.exc = (p[63:32] != {32{p[31]}});
    end else if (b == 32'd0) begin
      e.res = 32'd0;
      e.exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      q     = $signed(a) / $signed(b);
      e.res = q;
      e.exc = 1'b0;
    end
    e.cyc = ncyc + 33;
    sb.push_back(e);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    tick();
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done();
    int budget;
    budget = 60;
    while (sb.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("timeout", 64'(sb.size()), 64'd0);
    tick();
  endtask

  initial begin
    int t0;
    n_vec = 0; n_err = 0; ncyc = 0;
    last_res = '0; last_exc = 1'b0;
    reset_n = 1'b0;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;

    #1;
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exc", 64'(data_exception), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // multiply with busy profile across the whole operation
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    check("busy_c1", 64'(busy), 64'd1);
    for (int i = 2; i <= 34; i++) begin
      tick();
      check("busy_profile", 64'(busy), 64'(i <= 33));
    end
    repeat (4) tick();
    check("hold_result", 64'(data_result), 64'(last_res));
    check("hold_exc", 64'(data_exception), 64'(last_exc));

    start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000); wait_done();
    start_op(1'b0, 1'b1, 32'hFFFF_FFEA, 32'd4);         wait_done();
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
    start_op(1'b0, 1'b1, 32'd5, 32'd0);                 wait_done();
    start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000); wait_done();
    start_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
    start_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);         wait_done();

    // abort: DIV pulsed at cycle 10 of a MULT
    t0 = ncyc;
    start_op(1'b1, 1'b0, 32'd3, 32'd3);
    while (ncyc < t0 + 10) tick();
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    wait_done();
    check("abort_result", 64'(last_res), 64'd14);

    // asynchronous reset in cycle 15 of a MULT
    t0 = ncyc;
    start_op(1'b1, 1'b0, 32'd9, 32'd9);
    while (ncyc < t0 + 15) tick();
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_result", 64'(data_result), 64'd0);
    check("rst_mid_exc", 64'(data_exception), 64'd0);
    check("rst_mid_rdy", 64'(data_resultRDY), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    sb.delete();
    tick();
    reset_n = 1'b1;
    repeat (40) tick();

    // simultaneous starts: MULT wins
    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    wait_done();
    check("both_start_result", 64'(last_res), 64'd18);

    // restart in the DONE cycle
    t0 = ncyc;
    start_op(1'b0, 1'b1, 32'd1000, 32'd10);
    while (ncyc < t0 + 33) tick();
    start_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("busy_after_done_restart", 64'(busy), 64'd1);
    wait_done();

    for (int k = 0; k < 8; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (k == 3) ? 32'd0 : ((k % 2 == 1) ? ($urandom & 32'h0000_FFFF) : $urandom);
      start_op(k % 2 == 0, k % 2 == 1, a, b);
      wait_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
